// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq -- dot-product sequencer driving an external two-stage MAC.
//
// One job is requested with start/len/base. The sequencer clears the MAC,
// streams len operand pairs out of the operand buffer starting at base, waits
// for the read latency and the MAC pipeline to empty, and then captures
// mac_out into result with a one-cycle done pulse. A zero-length job completes
// immediately with result = 0.
//
// Parameters:
//   WIDTH   operand/result bit width
//   ADDR_W  operand-buffer address width
//
// Ports:
//   clk        clock, all state on the rising edge
//   rstb       asynchronous active-low reset
//   start      job request, sampled only in IDLE
//   len        dot-product length (ADDR_W+1 bits), sampled with start
//   base       first operand address, sampled with start
//   busy       high from the cycle after acceptance until the job completes
//   done       one-cycle pulse, result valid
//   result     captured dot product, held until the next capture
//   rd_en      operand-buffer read strobe
//   rd_addr    operand-buffer read address (wraps modulo 2^ADDR_W)
//   rd_data_a  input operand, valid the cycle after rd_en
//   rd_data_b  weight operand, valid the cycle after rd_en
//   mac_a      MAC operand A (zero when no read data is returning)
//   mac_b      MAC operand B (zero when no read data is returning)
//   mac_clr_n  active-low MAC clear, registered
//   mac_out    MAC accumulated output
//
// Configuration:
//   MAC_SEQ_RELU_EN  when defined, negative MAC results are captured as zero.
// -----------------------------------------------------------------------------
module mac_seq #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     start,
    input  logic        [ADDR_W:0]   len,
    input  logic        [ADDR_W-1:0] base,
    output logic                     busy,
    output logic                     done,
    output logic signed [WIDTH-1:0]  result,
    output logic                     rd_en,
    output logic        [ADDR_W-1:0] rd_addr,
    input  logic signed [WIDTH-1:0]  rd_data_a,
    input  logic signed [WIDTH-1:0]  rd_data_b,
    output logic signed [WIDTH-1:0]  mac_a,
    output logic signed [WIDTH-1:0]  mac_b,
    output logic                     mac_clr_n,
    input  logic signed [WIDTH-1:0]  mac_out
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   len_p0;
    logic [ADDR_W-1:0] base_p0;
    logic [ADDR_W:0]   idx;
    logic [1:0]        drain_cnt;
    logic              vld_p1;

    // Final shaping of the MAC value at capture time.
    function automatic logic signed [WIDTH-1:0] shape_result(
        input logic signed [WIDTH-1:0] v
    );
`ifdef MAC_SEQ_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            mac_clr_n <= 1'b0;
            len_p0    <= '0;
            base_p0   <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            vld_p1    <= 1'b0;
        end else begin
            done      <= 1'b0;
            mac_clr_n <= 1'b1;
            // Read data returns one cycle after each strobe.
            vld_p1    <= rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_p0    <= len;
                            base_p0   <= base;
                            busy      <= 1'b1;
                            mac_clr_n <= 1'b0;
                            state     <= CLEAR;
                        end else begin
                            result <= '0;
                            done   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    rd_en   <= 1'b1;
                    rd_addr <= base_p0;
                    idx     <= (ADDR_W + 1)'(1);
                    state   <= ISSUE;
                end
                ISSUE: begin
                    // idx counts strobes already issued; stop after len of them.
                    if (idx == len_p0) begin
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_addr <= base_p0 + idx[ADDR_W-1:0];
                        idx     <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // One read-latency cycle plus two MAC pipeline stages.
                    if (drain_cnt == 2'd2) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    result <= shape_result(mac_out);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Operands pass straight through only while read data is returning.
    assign mac_a = vld_p1 ? rd_data_a : '0;
    assign mac_b = vld_p1 ? rd_data_b : '0;

endmodule

// File: tb/tb_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_seq -- directed testbench for mac_seq.
// Provides an operand-buffer model with one cycle of read latency and a
// two-stage MAC model (registered product, then accumulator) cleared by
// mac_clr_n. Jobs are applied with hand-computed expected dot products.
// -----------------------------------------------------------------------------
module tb_mac_seq;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 8;

    logic                     clk = 1'b0;
    logic                     rstb = 1'b0;
    logic                     start = 1'b0;
    logic        [ADDR_W:0]   len = '0;
    logic        [ADDR_W-1:0] base = '0;
    logic                     busy;
    logic                     done;
    logic signed [WIDTH-1:0]  result;
    logic                     rd_en;
    logic        [ADDR_W-1:0] rd_addr;
    logic signed [WIDTH-1:0]  rd_data_a = '0;
    logic signed [WIDTH-1:0]  rd_data_b = '0;
    logic signed [WIDTH-1:0]  mac_a;
    logic signed [WIDTH-1:0]  mac_b;
    logic                     mac_clr_n;
    logic signed [WIDTH-1:0]  mac_out;

    logic signed [WIDTH-1:0]  mem_a [256];
    logic signed [WIDTH-1:0]  mem_b [256];
    logic signed [WIDTH-1:0]  prod;
    logic signed [WIDTH-1:0]  acc;

    int n_vec = 0;
    int n_err = 0;

    mac_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .len       (len),
        .base      (base),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clr_n (mac_clr_n),
        .mac_out   (mac_out)
    );

    always #5 clk = ~clk;

    // Operand buffer: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    // Two-stage MAC with wrapping WIDTH-bit arithmetic.
    always @(posedge clk or negedge mac_clr_n) begin
        if (!mac_clr_n) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            prod <= mac_a * mac_b;
            acc  <= acc + prod;
        end
    end
    assign mac_out = acc;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_job(input int n, input int b, input int hold,
                           input int exp_res, input string tag);
        int done_cyc   = -1;
        int done_cnt   = 0;
        int busy_first = -1;
        int busy_last  = -1;
        int busy_cnt   = 0;
        int rd_first   = -1;
        int rd_cnt     = 0;
        int clr_cyc    = -1;
        int clr_cnt    = 0;
        int addr_bad   = 0;
        int mac_bad    = 0;
        logic       prev_rd   = 1'b0;
        logic [7:0] prev_addr = '0;
        logic [7:0] ea;
        logic signed [WIDTH-1:0] ema;
        logic signed [WIDTH-1:0] emb;
        @(negedge clk);
        len   = n[ADDR_W:0];
        base  = b[ADDR_W-1:0];
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n + 8; c++) begin
            @(negedge clk);
            if (c >= hold) start = 1'b0;
            ema = prev_rd ? mem_a[prev_addr] : '0;
            emb = prev_rd ? mem_b[prev_addr] : '0;
            if (mac_a != ema || mac_b != emb) mac_bad++;
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (!mac_clr_n) begin
                if (clr_cyc < 0) clr_cyc = c;
                clr_cnt++;
            end
            if (rd_en) begin
                if (rd_first < 0) rd_first = c;
                ea = b[7:0] + rd_cnt[7:0];
                if (rd_addr != ea) addr_bad++;
                rd_cnt++;
            end
            prev_rd   = rd_en;
            prev_addr = rd_addr;
            if (done) begin
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk({tag, "_result_at_done"}, int'(result), exp_res);
                end
                done_cnt++;
            end
        end
        chk({tag, "_done_cycle"}, done_cyc, (n == 0) ? 1 : n + 6);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, (n == 0) ? 0 : n + 5);
        chk({tag, "_rd_count"}, rd_cnt, n);
        chk({tag, "_clr_count"}, clr_cnt, (n == 0) ? 0 : 1);
        if (n > 0) begin
            chk({tag, "_busy_first"}, busy_first, 1);
            chk({tag, "_busy_last"}, busy_last, n + 5);
            chk({tag, "_clr_cycle"}, clr_cyc, 1);
            chk({tag, "_rd_first"}, rd_first, 2);
        end
        chk({tag, "_addr_seq"}, addr_bad, 0);
        chk({tag, "_mac_operands"}, mac_bad, 0);
        chk({tag, "_result_held"}, int'(result), exp_res);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_mac_a"}, int'(mac_a), 0);
        chk({tag, "_mac_b"}, int'(mac_b), 0);
        chk({tag, "_mac_clr_n"}, int'(mac_clr_n), 0);
    endtask

    initial begin
        int res2;
        int done_seen;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        // Job 1 vectors at 10..13
        mem_a[10] = 16'sd1;  mem_b[10] = 16'sd5;
        mem_a[11] = 16'sd2;  mem_b[11] = 16'sd6;
        mem_a[12] = 16'sd3;  mem_b[12] = 16'sd7;
        mem_a[13] = 16'sd4;  mem_b[13] = 16'sd8;
        // Job 2 vectors at 20..22
        mem_a[20] = -16'sd2; mem_b[20] = 16'sd5;
        mem_a[21] = 16'sd3;  mem_b[21] = 16'sd5;
        mem_a[22] = -16'sd4; mem_b[22] = 16'sd5;
        // Job 3 vector at 30
        mem_a[30] = 16'sd7;  mem_b[30] = 16'sd3;
        // Wrapping-address job at 254,255,0,1
        mem_a[254] = 16'sd1; mem_b[254] = 16'sd2;
        mem_a[255] = 16'sd1; mem_b[255] = 16'sd3;
        mem_a[0]   = 16'sd1; mem_b[0]   = 16'sd4;
        mem_a[1]   = 16'sd1; mem_b[1]   = 16'sd5;
        // Product wrap at 40
        mem_a[40] = 16'sd256; mem_b[40] = 16'sd256;

        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("por_release_clr_n", int'(mac_clr_n), 1);

        // 1*5+2*6+3*7+4*8 = 70; start held while busy must be ignored
        run_job(4, 10, 4, 70, "dot4");
        // -10+15-20 = -15
`ifdef MAC_SEQ_RELU_EN
        res2 = 0;
`else
        res2 = -15;
`endif
        run_job(3, 20, 1, res2, "signed3");
        // 7*3 = 21, only correct if the MAC was cleared
        run_job(1, 30, 1, 21, "clear1");
        run_job(0, 0, 1, 0, "len0");
        // 2+3+4+5 = 14, addresses 254,255,0,1
        run_job(4, 254, 1, 14, "wrap_addr");
        // 256*256 = 65536 -> 0 modulo 2^16
        run_job(1, 40, 1, 0, "prod_wrap");

        // Abort in ISSUE
        run_job(1, 30, 1, 21, "pre_abort");
        @(negedge clk);
        len   = 9'd4;
        base  = 8'd10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_issue_rd_en", int'(rd_en), 1);
        #2;
        rstb = 1'b0;
        #1;
        chk_reset_outputs("abort");
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rstb = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (i == 0) chk("abort_release_clr_n", int'(mac_clr_n), 1);
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_busy_idle", int'(busy), 0);
        run_job(4, 10, 1, 70, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
